// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch front end: state enum, width defaults, branch targets.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int PC_W_DEF  = 10;
  localparam int LUT_W_DEF = 5;
  localparam int LUT_DEPTH = 1 << LUT_W_DEF;

  // Program-specific absolute branch targets, indexed by the instruction's LUT field.
  // Edit this table together with the program image it belongs to.
  localparam logic [PC_W_DEF-1:0] BRANCH_LUT [LUT_DEPTH] = '{
    10'h000, 10'h010, 10'h3FF, 10'h040, 10'h020, 10'h005, 10'h100, 10'h1A3,
    10'h2F0, 10'h0FF, 10'h3FE, 10'h080, 10'h055, 10'h2AA, 10'h123, 10'h321,
    10'h200, 10'h00C, 10'h3C0, 10'h0F0, 10'h111, 10'h222, 10'h333, 10'h044,
    10'h188, 10'h2CC, 10'h07F, 10'h300, 10'h1FF, 10'h3FD, 10'h0AB, 10'h155
  };

endpackage

// File: rtl/fetch_sequencer_if.sv
// Handshake and fetch bus between the top level and the fetch sequencer.
// Latency: n/a (wires only); optional perf counters appear when FETCH_PERF_CNT_EN is defined.
// Backpressure: stall holds the PC; no other flow control on this bus.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_W = LUT_W_DEF
);

  logic             start;
  logic             stall;
  logic             Branch;
  logic             taken;
  logic [LUT_W-1:0] lut_idx;
  logic             halt_req;
  logic [PC_W-1:0]  instr_addr;
  logic             fetch_valid;
  logic             busy;
  logic             done;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]      cycle_cnt;
  logic [15:0]      branch_cnt;
`endif

  // Control side: drives start and the per-instruction decode/ALU flags.
  modport master (
    output start, stall, Branch, taken, lut_idx, halt_req,
    input  instr_addr, fetch_valid, busy, done
`ifdef FETCH_PERF_CNT_EN
    , input cycle_cnt, branch_cnt
`endif
  );

  // Sequencer side: owns the PC and status outputs.
  modport slave (
    input  start, stall, Branch, taken, lut_idx, halt_req,
    output instr_addr, fetch_valid, busy, done
`ifdef FETCH_PERF_CNT_EN
    , output cycle_cnt, branch_cnt
`endif
  );

endinterface

// File: rtl/fetch_sequencer_branch_lut.sv
// Branch target lookup: maps the instruction LUT index to an absolute PC.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LUT_W = LUT_W_DEF
) (
  input  logic [LUT_W-1:0] lut_idx,
  output logic [PC_W-1:0]  target
);

  // Table read; target is used unmodified by the sequencer.
  always_comb begin
    target = PC_W'(BRANCH_LUT[lut_idx]);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner: IDLE/RUN/DONE sequencing, branch redirect, end-of-memory stop (perf counters under FETCH_PERF_CNT_EN).
// Latency: next PC registered one cycle after the deciding inputs; fetch_valid rises the cycle after start.
// Backpressure: stall holds the PC in RUN; start is ignored while running.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          PC_W       = PC_W_DEF,
  parameter int          LUT_W      = LUT_W_DEF,
  parameter int unsigned START_ADDR = 0
) (
  input logic              clk,
  input logic              reset,
  fetch_sequencer_if.slave bus
);

  localparam logic [PC_W-1:0] PC_LAST  = '1;
  localparam logic [PC_W-1:0] PC_START = PC_W'(START_ADDR);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] br_target;
  logic            br_taken;
  logic            start_run;

  branch_lut #(.PC_W(PC_W), .LUT_W(LUT_W)) u_branch_lut (
    .lut_idx (bus.lut_idx),
    .target  (br_target)
  );

  // Next state / next PC: halt beats stall beats taken branch beats fall-through.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    br_taken  = 1'b0;
    start_run = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d   = RUN;
          pc_d      = PC_START;
          start_run = 1'b1;
        end
      end
      RUN: begin
        if (bus.halt_req) begin
          state_d = DONE;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (bus.Branch && bus.taken) begin
          pc_d     = br_target;
          br_taken = 1'b1;
        end else if (pc_q == PC_LAST) begin
          // Falling off the end of memory stops rather than wrapping to 0.
          state_d = DONE;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // State and PC registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.instr_addr  = pc_q;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] branch_cnt_q, branch_cnt_d;

  // Saturating counters; cleared on the start that enters RUN, frozen outside RUN.
  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (start_run) begin
      cycle_cnt_d  = '0;
      branch_cnt_d = '0;
    end else if (state_q == RUN) begin
      if (cycle_cnt_q != '1) begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
      end
      if (br_taken && (branch_cnt_q != '1)) begin
        branch_cnt_d = branch_cnt_q + 16'd1;
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign bus.cycle_cnt  = cycle_cnt_q;
  assign bus.branch_cnt = branch_cnt_q;
`else
  // start_run only feeds the perf counters; keep it referenced in the lean build.
  logic unused_start_run;
  assign unused_start_run = start_run;
`endif

endmodule
